// File: rtl/dram_block_queue_mgr_pkg.sv
// Shared definitions for the DRAM block queue manager.
// Holds the control bit positions, the transfer FSM state encodings and a
// minimum-one log2 helper used to size queue index fields.
package dram_block_queue_mgr_pkg;

   localparam int unsigned CTRL_W      = 2;
   localparam int unsigned CTRL_ENABLE = 0;
   localparam int unsigned CTRL_REINIT = 1;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
   localparam logic [ST_W-1:0] ST_XFER = 2'd2;

   // Bits needed to index n items; never less than 1.
   function automatic int unsigned log2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/dram_rr_xfer_fsm.sv
// Round-robin arbiter plus IDLE/REQ/XFER handshake FSM for one DRAM direction.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   elig            per-queue eligibility (already gated by enable/status)
//   blk_ptrs        flat per-queue current block pointers, queue q at [q*BW +: BW]
//   ack, done       DRAM state-machine handshake inputs
//   req, ptr, queue DRAM request, word address and queue of the active grant
//   block_done      one-cycle completion pulse per queue
//   idle_c          FSM is in IDLE this cycle
//   fire_c          transfer of `queue` completes at the coming edge
module dram_rr_xfer_fsm
   import dram_block_queue_mgr_pkg::*;
#(
   parameter int unsigned NUM_QUEUES = 4,
   parameter int unsigned QW         = 2,
   parameter int unsigned BW         = 12,
   parameter int unsigned AW         = 22,
   parameter int unsigned SHIFT      = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_QUEUES-1:0]    elig,
   input  logic [NUM_QUEUES*BW-1:0] blk_ptrs,
   input  logic                     ack,
   input  logic                     done,
   output logic                     req,
   output logic [AW-1:0]            ptr,
   output logic [QW-1:0]            queue,
   output logic [NUM_QUEUES-1:0]    block_done,
   output logic                     idle_c,
   output logic                     fire_c
);

   localparam int unsigned EW = AW + BW;

   logic [ST_W-1:0]       state, state_d;
   logic                  req_d;
   logic [AW-1:0]         ptr_d;
   logic [QW-1:0]         queue_d, last, last_d;
   logic [NUM_QUEUES-1:0] done_d;
   logic [NUM_QUEUES-1:0] elig_m;
   logic                  found;
   logic [QW-1:0]         pick, cand;
   logic [BW-1:0]         pick_blk;

   // Round-robin search from last+1; a queue whose done pulse is showing
   // this cycle is skipped so its stale request level cannot re-grant.
   always_comb begin
      elig_m = elig & ~block_done;
      found  = 1'b0;
      pick   = '0;
      cand   = '0;
      for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
         cand = QW'((32'(last) + i) % NUM_QUEUES);
         if (!found && elig_m[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign pick_blk = blk_ptrs[32'(pick)*BW +: BW];
   assign idle_c   = (state == ST_IDLE);

   // Next state and registered outputs.
   always_comb begin
      state_d = state;
      req_d   = req;
      ptr_d   = ptr;
      queue_d = queue;
      last_d  = last;
      done_d  = '0;
      fire_c  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_REQ;
               req_d   = 1'b1;
               queue_d = pick;
               ptr_d   = AW'(EW'(pick_blk) << SHIFT);
            end
         end
         ST_REQ: begin
            if (ack) begin
               state_d = ST_XFER;
               req_d   = 1'b0;
            end
         end
         ST_XFER: begin
            if (done) begin
               state_d       = ST_IDLE;
               fire_c        = 1'b1;
               last_d        = queue;
               done_d[queue] = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         req        <= 1'b0;
         ptr        <= '0;
         queue      <= '0;
         last       <= QW'(NUM_QUEUES - 1);
         block_done <= '0;
      end else begin
         state      <= state_d;
         req        <= req_d;
         ptr        <= ptr_d;
         queue      <= queue_d;
         last       <= last_d;
         block_done <= done_d;
      end
   end

endmodule

// File: rtl/dram_block_queue_mgr.sv
// Multi-queue DRAM block pointer manager and write/read request arbiter.
// Keeps NUM_QUEUES circular block regions in one DRAM and drives one DRAM
// state-machine write port and one read port.
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   ctrl                               bit0 enable, bit1 reinit request
//   block_addr_lo/hi                   per-queue region bounds (flat)
//   wr_block_req/rd_block_req          per-queue block requests (level)
//   wr_block_done/rd_block_done        per-queue completion pulses
//   dram_wr_*/dram_rd_*                DRAM SM request/ack/done handshakes
//   queue_full/queue_empty             per-queue status
//   wr_addr/rd_addr                    current block pointers (flat)
module dram_block_queue_mgr
   import dram_block_queue_mgr_pkg::*;
#(
   parameter int unsigned NUM_QUEUES                 = 4,
   parameter int unsigned DRAM_ADDR_WIDTH            = 22,
   parameter int unsigned DRAM_BLOCK_RDWR_ADDR_WIDTH = 12,
   parameter int unsigned BLOCK_ADDR_SHIFT           = 8
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic [CTRL_W-1:0]                                  ctrl,
   input  logic [NUM_QUEUES*DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0]   block_addr_lo,
   input  logic [NUM_QUEUES*DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0]   block_addr_hi,
   input  logic [NUM_QUEUES-1:0]                              wr_block_req,
   output logic [NUM_QUEUES-1:0]                              wr_block_done,
   input  logic [NUM_QUEUES-1:0]                              rd_block_req,
   output logic [NUM_QUEUES-1:0]                              rd_block_done,
   output logic                                               dram_wr_req,
   output logic [DRAM_ADDR_WIDTH-1:0]                         dram_wr_ptr,
   output logic [log2_min1(NUM_QUEUES)-1:0]                   dram_wr_queue,
   input  logic                                               dram_wr_ack,
   input  logic                                               dram_wr_done,
   output logic                                               dram_rd_req,
   output logic [DRAM_ADDR_WIDTH-1:0]                         dram_rd_ptr,
   output logic [log2_min1(NUM_QUEUES)-1:0]                   dram_rd_queue,
   input  logic                                               dram_rd_ack,
   input  logic                                               dram_rd_done,
   output logic [NUM_QUEUES-1:0]                              queue_full,
   output logic [NUM_QUEUES-1:0]                              queue_empty,
   output logic [NUM_QUEUES*DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0]   wr_addr,
   output logic [NUM_QUEUES*DRAM_BLOCK_RDWR_ADDR_WIDTH-1:0]   rd_addr
);

   localparam int unsigned NQ = NUM_QUEUES;
   localparam int unsigned QW = log2_min1(NUM_QUEUES);
   localparam int unsigned BW = DRAM_BLOCK_RDWR_ADDR_WIDTH;
   localparam int unsigned CW = BW + 1;

   logic [NQ-1:0] full_c, empty_c, wr_elig, rd_elig;
   logic          grant_gate;
   logic          reinit_pending, reinit_pending_d;
   logic          load_c;
   logic          wr_idle_c, wr_fire_c, rd_idle_c, rd_fire_c;

   // No new grants while disabled or while a reinit is requested/pending.
   assign grant_gate = ctrl[CTRL_ENABLE] & ~ctrl[CTRL_REINIT] & ~reinit_pending;

   // Reinit load waits for both directions to be idle so in-flight blocks finish.
   assign load_c = (reinit_pending | ctrl[CTRL_REINIT]) & wr_idle_c & rd_idle_c;

   always_comb begin
      reinit_pending_d = reinit_pending;
      if (ctrl[CTRL_REINIT]) reinit_pending_d = 1'b1;
      else if (load_c)       reinit_pending_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) reinit_pending <= 1'b0;
      else        reinit_pending <= reinit_pending_d;
   end

   // Per-queue pointers, occupancy and status.
   for (genvar g = 0; g < NQ; g++) begin : g_q
      logic [BW-1:0] lo, hi, wp, rp, wp_d, rp_d;
      logic [CW-1:0] cnt, cnt_d, cap;
      logic          invalid, wr_hit, rd_hit, full_q, empty_q;

      assign lo      = block_addr_lo[g*BW +: BW];
      assign hi      = block_addr_hi[g*BW +: BW];
      assign invalid = (lo > hi);
      assign cap     = CW'(hi) - CW'(lo) + CW'(1);

      assign full_c[g]  = invalid | (cnt == cap);
      assign empty_c[g] = invalid | (cnt == '0);
      assign wr_elig[g] = wr_block_req[g] & ~full_c[g] & grant_gate;
      assign rd_elig[g] = rd_block_req[g] & ~empty_c[g] & grant_gate;

      assign wr_hit = wr_fire_c & (dram_wr_queue == QW'(g));
      assign rd_hit = rd_fire_c & (dram_rd_queue == QW'(g));

      // Same-cycle write and read completions cancel in the count.
      always_comb begin
         wp_d  = wp;
         rp_d  = rp;
         cnt_d = cnt;
         if (load_c) begin
            wp_d  = lo;
            rp_d  = lo;
            cnt_d = '0;
         end else begin
            if (wr_hit) wp_d = (wp == hi) ? lo : wp + BW'(1);
            if (rd_hit) rp_d = (rp == hi) ? lo : rp + BW'(1);
            if (wr_hit && !rd_hit)      cnt_d = cnt + CW'(1);
            else if (rd_hit && !wr_hit) cnt_d = cnt - CW'(1);
         end
      end

      // Status registered from the next count so it lines up with done pulses.
      always_ff @(posedge clk) begin
         if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            full_q  <= invalid;
            empty_q <= 1'b1;
         end else begin
            wp      <= wp_d;
            rp      <= rp_d;
            cnt     <= cnt_d;
            full_q  <= invalid | (cnt_d == cap);
            empty_q <= invalid | (cnt_d == '0);
         end
      end

      assign queue_full[g]          = full_q;
      assign queue_empty[g]         = empty_q;
      assign wr_addr[g*BW +: BW]    = wp;
      assign rd_addr[g*BW +: BW]    = rp;
   end

   dram_rr_xfer_fsm #(
      .NUM_QUEUES (NQ),
      .QW         (QW),
      .BW         (BW),
      .AW         (DRAM_ADDR_WIDTH),
      .SHIFT      (BLOCK_ADDR_SHIFT)
   ) u_wr_fsm (
      .clk        (clk),
      .reset      (reset),
      .elig       (wr_elig),
      .blk_ptrs   (wr_addr),
      .ack        (dram_wr_ack),
      .done       (dram_wr_done),
      .req        (dram_wr_req),
      .ptr        (dram_wr_ptr),
      .queue      (dram_wr_queue),
      .block_done (wr_block_done),
      .idle_c     (wr_idle_c),
      .fire_c     (wr_fire_c)
   );

   dram_rr_xfer_fsm #(
      .NUM_QUEUES (NQ),
      .QW         (QW),
      .BW         (BW),
      .AW         (DRAM_ADDR_WIDTH),
      .SHIFT      (BLOCK_ADDR_SHIFT)
   ) u_rd_fsm (
      .clk        (clk),
      .reset      (reset),
      .elig       (rd_elig),
      .blk_ptrs   (rd_addr),
      .ack        (dram_rd_ack),
      .done       (dram_rd_done),
      .req        (dram_rd_req),
      .ptr        (dram_rd_ptr),
      .queue      (dram_rd_queue),
      .block_done (rd_block_done),
      .idle_c     (rd_idle_c),
      .fire_c     (rd_fire_c)
   );

endmodule

// File: tb/tb_dram_block_queue_mgr.sv
// Bench for dram_block_queue_mgr: acts as the DRAM state machine and the
// queue requesters, with expected grants queued up front and compared as
// the DUT issues each DRAM request.
module tb_dram_block_queue_mgr;

   localparam int unsigned NQ = 4;
   localparam int unsigned QW = 2;
   localparam int unsigned BW = 12;
   localparam int unsigned AW = 22;

   typedef struct packed {
      logic [QW-1:0] q;
      logic [AW-1:0] p;
   } xfer_t;

   logic            clk;
   logic            reset;
   logic [1:0]      ctrl;
   logic [NQ*BW-1:0] block_addr_lo, block_addr_hi;
   logic [NQ-1:0]   wr_block_req, wr_block_done, rd_block_req, rd_block_done;
   logic            dram_wr_req, dram_wr_ack, dram_wr_done;
   logic [AW-1:0]   dram_wr_ptr;
   logic [QW-1:0]   dram_wr_queue;
   logic            dram_rd_req, dram_rd_ack, dram_rd_done;
   logic [AW-1:0]   dram_rd_ptr;
   logic [QW-1:0]   dram_rd_queue;
   logic [NQ-1:0]   queue_full, queue_empty;
   logic [NQ*BW-1:0] wr_addr, rd_addr;

   int    checks = 0;
   int    errors = 0;
   xfer_t wr_exp[$];
   xfer_t rd_exp[$];

   dram_block_queue_mgr dut (
      .clk           (clk),
      .reset         (reset),
      .ctrl          (ctrl),
      .block_addr_lo (block_addr_lo),
      .block_addr_hi (block_addr_hi),
      .wr_block_req  (wr_block_req),
      .wr_block_done (wr_block_done),
      .rd_block_req  (rd_block_req),
      .rd_block_done (rd_block_done),
      .dram_wr_req   (dram_wr_req),
      .dram_wr_ptr   (dram_wr_ptr),
      .dram_wr_queue (dram_wr_queue),
      .dram_wr_ack   (dram_wr_ack),
      .dram_wr_done  (dram_wr_done),
      .dram_rd_req   (dram_rd_req),
      .dram_rd_ptr   (dram_rd_ptr),
      .dram_rd_queue (dram_rd_queue),
      .dram_rd_ack   (dram_rd_ack),
      .dram_rd_done  (dram_rd_done),
      .queue_full    (queue_full),
      .queue_empty   (queue_empty),
      .wr_addr       (wr_addr),
      .rd_addr       (rd_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1;
   endtask

   task automatic do_reinit();
      ctrl = 2'b11;
      tick(); tick();
      ctrl = 2'b01;
      tick(); tick();
   endtask

   function automatic xfer_t mk(input int q, input int blk);
      xfer_t x;
      x.q = QW'(q);
      x.p = AW'(blk * 256);
      return x;
   endfunction

   // Full write handshake as the DRAM SM; ok=0 if no request appeared.
   task automatic wr_xfer(output xfer_t got, output bit ok);
      ok  = 1'b0;
      got = '0;
      for (int i = 0; i < 20; i++) begin
         if (dram_wr_req) break;
         tick();
      end
      if (!dram_wr_req) return;
      got.q = dram_wr_queue;
      got.p = dram_wr_ptr;
      dram_wr_ack = 1'b1; tick(); dram_wr_ack = 1'b0;
      tick();
      dram_wr_done = 1'b1; tick(); dram_wr_done = 1'b0;
      ok = 1'b1;
   endtask

   task automatic rd_xfer(output xfer_t got, output bit ok);
      ok  = 1'b0;
      got = '0;
      for (int i = 0; i < 20; i++) begin
         if (dram_rd_req) break;
         tick();
      end
      if (!dram_rd_req) return;
      got.q = dram_rd_queue;
      got.p = dram_rd_ptr;
      dram_rd_ack = 1'b1; tick(); dram_rd_ack = 1'b0;
      tick();
      dram_rd_done = 1'b1; tick(); dram_rd_done = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (dram_wr_req !== 1'b0 || dram_rd_req !== 1'b0) begin
         errors++; $display("FAIL reset_req: wr=%b rd=%b required 0 0", dram_wr_req, dram_rd_req);
      end
      checks++;
      if (wr_addr !== '0 || rd_addr !== '0) begin
         errors++; $display("FAIL reset_ptrs: wr_addr=%h rd_addr=%h required 0", wr_addr, rd_addr);
      end
      checks++;
      if (queue_empty !== 4'b1111 || queue_full !== 4'b1000) begin
         errors++; $display("FAIL reset_status: empty=%b full=%b required 1111 1000", queue_empty, queue_full);
      end
      checks++;
      if (dram_wr_ptr !== '0 || dram_wr_queue !== '0 || wr_block_done !== '0) begin
         errors++; $display("FAIL reset_outputs: ptr=%h q=%0d done=%b required 0", dram_wr_ptr, dram_wr_queue, wr_block_done);
      end
   endtask

   task automatic test_write_fill();
      xfer_t got, exp;
      bit    ok, seen;
      for (int i = 0; i < 4; i++) wr_exp.push_back(mk(0, i));
      wr_block_req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         wr_xfer(got, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL write_fill_grant%0d: no dram_wr_req, required a grant", i);
         end else begin
            exp = wr_exp.pop_front();
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL write_fill_xfer%0d: q=%0d ptr=%h required q=%0d ptr=%h", i, got.q, got.p, exp.q, exp.p);
            end
         end
         checks++;
         if (wr_block_done !== 4'b0001) begin
            errors++; $display("FAIL write_fill_done%0d: %b required 0001", i, wr_block_done);
         end
         checks++;
         if (queue_full[0] !== (i == 3)) begin
            errors++; $display("FAIL write_fill_full%0d: %b required %b", i, queue_full[0], (i == 3));
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dram_wr_req) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL write_fill_fifth: dram_wr_req seen=1 required 0 while full");
      end
      wr_block_req = 4'b0000;
   endtask

   task automatic test_read_drain();
      xfer_t got, exp;
      bit    ok;
      for (int i = 0; i < 4; i++) rd_exp.push_back(mk(0, i));
      rd_block_req = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         rd_xfer(got, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL read_drain_grant%0d: no dram_rd_req, required a grant", i);
         end else begin
            exp = rd_exp.pop_front();
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL read_drain_xfer%0d: q=%0d ptr=%h required q=%0d ptr=%h", i, got.q, got.p, exp.q, exp.p);
            end
         end
         checks++;
         if (rd_block_done !== 4'b0001) begin
            errors++; $display("FAIL read_drain_done%0d: %b required 0001", i, rd_block_done);
         end
      end
      rd_block_req = 4'b0000;
      checks++;
      if (wr_addr[11:0] !== 12'd0 || rd_addr[11:0] !== 12'd0 || queue_empty[0] !== 1'b1) begin
         errors++; $display("FAIL read_drain_wrap: wr=%0d rd=%0d empty=%b required 0 0 1", wr_addr[11:0], rd_addr[11:0], queue_empty[0]);
      end
   endtask

   task automatic test_round_robin();
      xfer_t got, exp;
      bit    ok;
      do_reset();
      ctrl = 2'b01;
      do_reinit();
      wr_exp.push_back(mk(0, 0));
      wr_exp.push_back(mk(1, 4));
      wr_exp.push_back(mk(2, 8));
      wr_exp.push_back(mk(3, 12));
      wr_exp.push_back(mk(0, 1));
      wr_block_req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wr_xfer(got, ok);
         if (i == 4) wr_block_req = 4'b0000;
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rr_grant%0d: no dram_wr_req, required a grant", i);
         end else begin
            exp = wr_exp.pop_front();
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL rr_xfer%0d: q=%0d ptr=%h required q=%0d ptr=%h", i, got.q, got.p, exp.q, exp.p);
            end
         end
      end
      tick(); tick();
   endtask

   task automatic test_same_cycle();
      xfer_t got, exp;
      bit    ok;
      // Bring q1 to two blocks (one already from round robin).
      wr_exp.push_back(mk(1, 5));
      wr_block_req = 4'b0010;
      wr_xfer(got, ok);
      wr_block_req = 4'b0000;
      checks++;
      if (!ok) begin
         errors++; $display("FAIL same_prep: no dram_wr_req, required a grant");
      end else begin
         exp = wr_exp.pop_front();
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL same_prep_xfer: q=%0d ptr=%h required q=%0d ptr=%h", got.q, got.p, exp.q, exp.p);
         end
      end
      tick(); tick();
      wr_exp.push_back(mk(1, 6));
      rd_exp.push_back(mk(1, 4));
      wr_block_req = 4'b0010;
      rd_block_req = 4'b0010;
      tick();
      checks++;
      if (dram_wr_req !== 1'b1 || dram_rd_req !== 1'b1) begin
         errors++; $display("FAIL same_grant: wr=%b rd=%b required 1 1", dram_wr_req, dram_rd_req);
      end else begin
         exp = wr_exp.pop_front();
         checks++;
         if (dram_wr_queue !== exp.q || dram_wr_ptr !== exp.p) begin
            errors++; $display("FAIL same_wr_xfer: q=%0d ptr=%h required q=%0d ptr=%h", dram_wr_queue, dram_wr_ptr, exp.q, exp.p);
         end
         exp = rd_exp.pop_front();
         checks++;
         if (dram_rd_queue !== exp.q || dram_rd_ptr !== exp.p) begin
            errors++; $display("FAIL same_rd_xfer: q=%0d ptr=%h required q=%0d ptr=%h", dram_rd_queue, dram_rd_ptr, exp.q, exp.p);
         end
      end
      wr_block_req = 4'b0000;
      rd_block_req = 4'b0000;
      dram_wr_ack = 1'b1; dram_rd_ack = 1'b1;
      tick();
      dram_wr_ack = 1'b0; dram_rd_ack = 1'b0;
      checks++;
      if (dram_wr_req !== 1'b0 || dram_rd_req !== 1'b0) begin
         errors++; $display("FAIL same_ack_drop: wr=%b rd=%b required 0 0", dram_wr_req, dram_rd_req);
      end
      tick();
      dram_wr_done = 1'b1; dram_rd_done = 1'b1;
      tick();
      dram_wr_done = 1'b0; dram_rd_done = 1'b0;
      checks++;
      if (wr_block_done !== 4'b0010 || rd_block_done !== 4'b0010) begin
         errors++; $display("FAIL same_done: wr=%b rd=%b required 0010 0010", wr_block_done, rd_block_done);
      end
      checks++;
      if (wr_addr[23:12] !== 12'd7 || rd_addr[23:12] !== 12'd5 || queue_full[1] !== 1'b0 || queue_empty[1] !== 1'b0) begin
         errors++; $display("FAIL same_ptrs: wr=%0d rd=%0d full=%b empty=%b required 7 5 0 0",
                            wr_addr[23:12], rd_addr[23:12], queue_full[1], queue_empty[1]);
      end
      // Count stayed at 2: exactly two more writes fill the 4-block region.
      tick(); tick();
      wr_exp.push_back(mk(1, 7));
      wr_exp.push_back(mk(1, 4));
      wr_block_req = 4'b0010;
      for (int i = 0; i < 2; i++) begin
         wr_xfer(got, ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL same_fill_grant%0d: no dram_wr_req, required a grant", i);
         end else begin
            exp = wr_exp.pop_front();
            checks++;
            if (got !== exp) begin
               errors++; $display("FAIL same_fill_xfer%0d: q=%0d ptr=%h required q=%0d ptr=%h", i, got.q, got.p, exp.q, exp.p);
            end
         end
         checks++;
         if (queue_full[1] !== (i == 1)) begin
            errors++; $display("FAIL same_fill_full%0d: %b required %b", i, queue_full[1], (i == 1));
         end
      end
      wr_block_req = 4'b0000;
      tick(); tick();
   endtask

   task automatic test_reinit_during_xfer();
      xfer_t exp;
      bit    seen;
      wr_exp.push_back(mk(2, 9));
      wr_block_req = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         if (dram_wr_req) break;
         tick();
      end
      checks++;
      if (!dram_wr_req) begin
         errors++; $display("FAIL reinit_grant: dram_wr_req=0 required 1");
      end else begin
         exp = wr_exp.pop_front();
         checks++;
         if (dram_wr_queue !== exp.q || dram_wr_ptr !== exp.p) begin
            errors++; $display("FAIL reinit_xfer: q=%0d ptr=%h required q=%0d ptr=%h", dram_wr_queue, dram_wr_ptr, exp.q, exp.p);
         end
      end
      dram_wr_ack = 1'b1; tick(); dram_wr_ack = 1'b0;
      ctrl = 2'b11;
      wr_block_req = 4'b1111;
      rd_block_req = 4'b1111;
      tick();
      dram_wr_done = 1'b1; tick(); dram_wr_done = 1'b0;
      checks++;
      if (wr_block_done !== 4'b0100) begin
         errors++; $display("FAIL reinit_done: %b required 0100", wr_block_done);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (dram_wr_req || dram_rd_req) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL reinit_no_grant: request seen=1 required 0 while reinit");
      end
      checks++;
      if (wr_addr !== {12'd12, 12'd8, 12'd4, 12'd0} || rd_addr !== {12'd12, 12'd8, 12'd4, 12'd0}) begin
         errors++; $display("FAIL reinit_ptrs: wr=%h rd=%h required %h", wr_addr, rd_addr, {12'd12, 12'd8, 12'd4, 12'd0});
      end
      checks++;
      if (queue_empty !== 4'b1111 || queue_full !== 4'b0000) begin
         errors++; $display("FAIL reinit_status: empty=%b full=%b required 1111 0000", queue_empty, queue_full);
      end
      wr_block_req = 4'b0000;
      rd_block_req = 4'b0000;
      ctrl = 2'b01;
      tick(); tick();
   endtask

   task automatic test_invalid_queue();
      bit seen;
      block_addr_lo[47:36] = 12'd10;
      block_addr_hi[47:36] = 12'd5;
      wr_block_req = 4'b1000;
      rd_block_req = 4'b1000;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dram_wr_req || dram_rd_req) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL invalid_grant: request seen=1 required 0");
      end
      checks++;
      if (queue_full[3] !== 1'b1 || queue_empty[3] !== 1'b1) begin
         errors++; $display("FAIL invalid_status: full=%b empty=%b required 1 1", queue_full[3], queue_empty[3]);
      end
      wr_block_req = 4'b0000;
      rd_block_req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_req();
      xfer_t exp;
      wr_exp.push_back(mk(0, 0));
      wr_block_req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         if (dram_wr_req) break;
         tick();
      end
      checks++;
      if (!dram_wr_req) begin
         errors++; $display("FAIL rst_mid_grant: dram_wr_req=0 required 1");
      end else begin
         exp = wr_exp.pop_front();
         checks++;
         if (dram_wr_queue !== exp.q || dram_wr_ptr !== exp.p) begin
            errors++; $display("FAIL rst_mid_xfer: q=%0d ptr=%h required q=%0d ptr=%h", dram_wr_queue, dram_wr_ptr, exp.q, exp.p);
         end
      end
      reset = 1'b0;
      tick();
      checks++;
      if (dram_wr_req !== 1'b0 || wr_addr !== '0 || rd_addr !== '0) begin
         errors++; $display("FAIL rst_mid_abort: req=%b wr=%h rd=%h required 0 0 0", dram_wr_req, wr_addr, rd_addr);
      end
      reset = 1'b1;
      wr_block_req = 4'b0000;
      tick();
      checks++;
      if (wr_exp.size() != 0 || rd_exp.size() != 0) begin
         errors++; $display("FAIL scoreboard_left: wr=%0d rd=%0d required 0 0", wr_exp.size(), rd_exp.size());
      end
   endtask

   initial begin
      reset         = 1'b0;
      ctrl          = 2'b00;
      wr_block_req  = '0;
      rd_block_req  = '0;
      dram_wr_ack   = 1'b0;
      dram_wr_done  = 1'b0;
      dram_rd_ack   = 1'b0;
      dram_rd_done  = 1'b0;
      block_addr_lo = {12'd10, 12'd8, 12'd4, 12'd0};
      block_addr_hi = {12'd5, 12'd11, 12'd7, 12'd3};

      test_reset();
      ctrl = 2'b01;
      block_addr_lo[47:36] = 12'd12;
      block_addr_hi[47:36] = 12'd15;
      do_reinit();
      test_write_fill();
      test_read_drain();
      test_round_robin();
      test_same_cycle();
      test_reinit_during_xfer();
      test_invalid_queue();
      test_reset_mid_req();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_block_queue_mgr.md
# dram_block_queue_mgr

Multi-queue DRAM block pointer manager and request arbiter for the DRAM output-queue path. It keeps NUM_QUEUES independent circular block regions in one DRAM, each bounded by its own block_addr_lo/hi registers. It arbitrates round-robin among per-queue write and read block requests and drives a single DRAM state-machine write/read request port. It replaces the per-queue fixed pointer logic inside the store/remove pair so that several output queues can share one DRAM controller.

## Interface
- NUM_QUEUES, 4: number of queues; QW = log2(NUM_QUEUES), minimum 1.
- DRAM_ADDR_WIDTH, 22: DRAM word address width.
- DRAM_BLOCK_RDWR_ADDR_WIDTH, 12: block index width (BW).
- BLOCK_ADDR_SHIFT, 8: DRAM address = block index << BLOCK_ADDR_SHIFT, truncated to DRAM_ADDR_WIDTH.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- ctrl  in  2  bit0 enable (no new grants when 0); bit1 reinit request (level).
- block_addr_lo, block_addr_hi  in  NUM_QUEUES*BW  per-queue region bounds, queue q at [q*BW +: BW].
- wr_block_req  in  NUM_QUEUES  queue q has one block ready to write (level).
- wr_block_done  out  NUM_QUEUES  one-cycle pulse: block write for q completed.
- rd_block_req  in  NUM_QUEUES  queue q can accept one block (level).
- rd_block_done  out  NUM_QUEUES  one-cycle pulse: block read for q completed.
- dram_wr_req  out  1;  dram_wr_ptr  out  DRAM_ADDR_WIDTH;  dram_wr_queue  out  QW;  dram_wr_ack  in  1;  dram_wr_done  in  1.
- dram_rd_req  out  1;  dram_rd_ptr  out  DRAM_ADDR_WIDTH;  dram_rd_queue  out  QW;  dram_rd_ack  in  1;  dram_rd_done  in  1.
- queue_full, queue_empty  out  NUM_QUEUES  per-queue status.
- wr_addr, rd_addr  out  NUM_QUEUES*BW  current block pointers, for the register block.

## Operation
- Per queue: wr_ptr, rd_ptr (BW bits) and occupancy cnt (BW+1 bits); capacity = hi - lo + 1.
- full = (cnt == capacity); empty = (cnt == 0). If lo > hi, the queue is invalid: full = empty = 1 and it is never granted.
- Write eligibility for q: wr_block_req[q] & ~full[q] & ctrl[0] & ~reinit_pending.
- Read eligibility for q: rd_block_req[q] & ~empty[q] & ctrl[0] & ~reinit_pending.
- Write and read each have an independent FSM: IDLE -> REQ -> XFER -> IDLE.
  - IDLE: pick the first eligible queue round-robin, starting at last_served+1 mod NUM_QUEUES. Latch queue and pointer. Go to REQ.
  - REQ: hold req high with ptr and queue stable. On ack, drop req and go to XFER.
  - XFER: on done, advance that queue's pointer, update cnt, pulse *_block_done[q], set last_served = q, return to IDLE.
- Pointer advance: ptr == hi gives lo, otherwise ptr + 1.
- A write done increments cnt and a read done decrements it. If both hit the same queue in the same cycle, cnt is unchanged and both pointers advance.
- A read is only granted on a non-empty queue, so the read never overtakes the write.
- Reinit (ctrl[1] high):
  - Sets reinit_pending.
  - When both FSMs are IDLE, all wr_ptr and rd_ptr load lo and all cnt load 0.
  - reinit_pending clears on the cycle ctrl[1] is low after the load.
  - In-flight transfers always complete first.
- ack or done arriving in an unexpected state is ignored.

## Timing
- Reset values:
  - FSMs IDLE; req outputs 0; ptr and queue outputs 0; done pulses 0.
  - All pointers = 0 and cnt = 0. Pointers are not loaded from lo; software issues reinit after programming bounds.
  - last_served = NUM_QUEUES-1, so queue 0 has priority first.
  - reinit_pending 0; queue_empty all 1; queue_full = (lo > hi).
- Request sampled in IDLE at cycle N: req high from N+1.
- ack at cycle M: req low at M+1.
- done at cycle D: *_block_done pulse, updated pointer, cnt and status all visible at D+1. FSM re-enters IDLE at D+1 and can grant again at D+1, with req at D+2.
- A requester must drop or keep its request based on the done pulse. The req level seen in the cycle of its own done pulse is not considered for a new grant.
- Reset asserted mid-transfer aborts immediately with all state at reset values. The DRAM SM must be reset with this block.

## Structure
- Shared package (include file): control bit indices (CTRL_ENABLE=0, CTRL_REINIT=1), FSM state encodings, log2 function.
- One sub-module: dram_rr_xfer_fsm, the round-robin arbiter plus IDLE/REQ/XFER FSM. It is instantiated twice, for write and read.
- Pointer, count and status arrays live in the top level.

## Test plan
- Lo=0, hi=3 for q0: five writes. Each write gives ptr 0,1,2,3 with dram_wr_ptr = block << 8, and queue_full[0] rises after the 4th. The fifth request is not granted.
- q0 full with lo=0, hi=3: 4 reads return rd_ptr 0..3; then wr_ptr and rd_ptr both wrap to 0 and queue_empty[0] = 1.
- All 4 queues request writes continuously: grants go q0,q1,q2,q3,q0, with dram_wr_queue matching each grant.
- Same-cycle dram_wr_done and dram_rd_done on q1 with cnt=2: cnt stays 2 and both pointers advance by 1.
- Reinit asserted during the XFER of q2: the transfer completes with a done pulse, then all pointers equal lo and cnt = 0. No grant occurs while ctrl[1] = 1.
- q3 lo=10, hi=5: requests are never granted; queue_full[3] = queue_empty[3] = 1.
- Reset (reset=0) asserted during REQ: dram_wr_req = 0 in the next cycle and all pointers are 0.
